// File: rtl/paddle_controller.sv
// rtl/paddle_controller.sv - button-driven paddle position with per-frame acceleration ramp and wall clamping
module paddle_controller #(
  parameter int SCREEN_WIDTH = 640,
  parameter int PADDLE_WIDTH = 48,
  parameter int X_RESET      = 296,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_FRAMES = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       frame_tick,
  input  logic       freeze,
  output logic [9:0] x,
  output logic [3:0] speed,
  output logic       wall_hit
);

  localparam int XMAX = SCREEN_WIDTH - PADDLE_WIDTH;
  localparam int HW   = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t          state;
  state_t          dir;
  logic [1:0]      left_sync;
  logic [1:0]      right_sync;
  logic [HW-1:0]   hold_cnt;
  logic [3:0]      step;
  logic [10:0]     x_ext;
  logic [10:0]     x_sum;
  logic [9:0]      x_next;
  logic            clamp_hit;

  // A pulse is only reported when the clamp actually stopped motion short of the requested step.
  always_comb begin
    dir = IDLE;
    if (!freeze) begin
      if (left_sync[1] && !right_sync[1])
        dir = LEFT;
      else if (right_sync[1] && !left_sync[1])
        dir = RIGHT;
    end

    step      = (dir == state) ? speed : 4'd1;
    x_ext     = {1'b0, x};
    x_sum     = x_ext + {7'd0, step};
    x_next    = x;
    clamp_hit = 1'b0;

    if (dir == LEFT) begin
      if (x_ext < {7'd0, step}) begin
        x_next    = 10'd0;
        clamp_hit = (x != 10'd0);
      end else begin
        x_next = x - {6'd0, step};
      end
    end else if (dir == RIGHT) begin
      if (x_sum > 11'(XMAX)) begin
        x_next    = 10'(XMAX);
        clamp_hit = (x != 10'(XMAX));
      end else begin
        x_next = x_sum[9:0];
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      left_sync  <= 2'b00;
      right_sync <= 2'b00;
      state      <= IDLE;
      x          <= 10'(X_RESET);
      speed      <= 4'd0;
      hold_cnt   <= '0;
      wall_hit   <= 1'b0;
    end else begin
      left_sync  <= {left_sync[0], btn_left};
      right_sync <= {right_sync[0], btn_right};
      wall_hit   <= 1'b0;

      if (frame_tick) begin
        wall_hit <= clamp_hit;
        x        <= x_next;
        if (dir == IDLE) begin
          state    <= IDLE;
          speed    <= 4'd0;
          hold_cnt <= '0;
        end else if (dir != state) begin
          state    <= dir;
          speed    <= 4'd1;
          hold_cnt <= '0;
        end else if (hold_cnt == HW'(ACCEL_FRAMES - 1)) begin
          hold_cnt <= '0;
          if (speed < 4'(MAX_SPEED))
            speed <= speed + 4'd1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_paddle_controller.sv
// tb/tb_paddle_controller.sv - directed self-checking bench for paddle_controller
module tb_paddle_controller;

  logic       clk = 1'b0;
  logic       nRst;
  logic       btn_left;
  logic       btn_right;
  logic       frame_tick;
  logic       freeze;
  logic [9:0] x;
  logic [3:0] speed;
  logic       wall_hit;

  int checks = 0;
  int errors = 0;
  int m_x, m_spd, m_hold, m_st, m_hit;
  int hits;
  int ramp_x [6] = '{297, 298, 299, 300, 301, 303};

  always #5 clk = ~clk;

  paddle_controller dut (
    .clk        (clk),
    .nRst       (nRst),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .frame_tick (frame_tick),
    .freeze     (freeze),
    .x          (x),
    .speed      (speed),
    .wall_hit   (wall_hit)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 296; m_spd = 0; m_hold = 0; m_st = 0; m_hit = 0;
  endtask

  // Reference behaviour: 0 = idle, 1 = left, 2 = right; XMAX = 592.
  task automatic model_step(input bit l, input bit r, input bit f);
    int dir;
    int stp;
    dir = f ? 0 : (l && !r) ? 1 : (r && !l) ? 2 : 0;
    m_hit = 0;
    stp = 0;
    if (dir == 0) begin
      m_st = 0; m_spd = 0; m_hold = 0;
    end else if (dir != m_st) begin
      m_st = dir; stp = 1; m_spd = 1; m_hold = 0;
    end else begin
      stp = m_spd;
      if (m_hold == 3) begin
        m_hold = 0;
        if (m_spd < 8) m_spd++;
      end else begin
        m_hold++;
      end
    end
    if (dir == 1) begin
      if (m_x - stp < 0) begin m_hit = (m_x != 0); m_x = 0; end
      else m_x = m_x - stp;
    end else if (dir == 2) begin
      if (m_x + stp > 592) begin m_hit = (m_x != 592); m_x = 592; end
      else m_x = m_x + stp;
    end
  endtask

  task automatic frame_ex(input string tag, input bit l, input bit r);
    model_step(l, r, freeze);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check({tag, "_x"}, int'(x), m_x);
    check({tag, "_speed"}, int'(speed), m_spd);
    check({tag, "_hit"}, int'(wall_hit), m_hit);
    hits += int'(wall_hit);
    if (m_hit != 0) begin
      @(negedge clk);
      check({tag, "_hit_len"}, int'(wall_hit), 0);
    end
  endtask

  task automatic frame(input string tag);
    frame_ex(tag, btn_left, btn_right);
  endtask

  task automatic set_btn(input bit l, input bit r);
    @(negedge clk);
    btn_left  = l;
    btn_right = r;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    nRst = 1'b0; btn_left = 1'b0; btn_right = 1'b0; frame_tick = 1'b0; freeze = 1'b0;
    hits = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_x", int'(x), 296);
    check("rst_speed", int'(speed), 0);
    check("rst_hit", int'(wall_hit), 0);
    nRst = 1'b1;

    // Move a little, then reset asynchronously mid-cycle with right still held.
    set_btn(0, 1);
    frame("pre");
    frame("pre");
    #3 nRst = 1'b0;
    #1;
    check("arst_x", int'(x), 296);
    check("arst_speed", int'(speed), 0);
    check("arst_hit", int'(wall_hit), 0);
    model_reset();
    @(negedge clk);
    btn_right = 1'b0;
    nRst = 1'b1;
    for (int i = 0; i < 10; i++) frame("idle");
    check("idle_x", int'(x), 296);

    // Acceleration ramp.
    set_btn(0, 1);
    for (int i = 0; i < 6; i++) begin
      frame("ramp");
      check("ramp_x_hand", int'(x), ramp_x[i]);
      if (i == 4) check("ramp_speed5", int'(speed), 2);
    end
    repeat (5) begin
      @(negedge clk);
      check("stable_x", int'(x), 303);
    end
    for (int i = 0; i < 28; i++) begin
      frame("accel");
      check("speed_le_max", int'(speed <= 4'd8), 1);
    end
    check("speed_sat", int'(speed), 8);
    check("accel_x", int'(x), 449);

    // Reversal restarts the ramp from speed 1.
    set_btn(1, 0);
    frame("rev");
    check("rev_x", int'(x), 448);
    check("rev_speed", int'(speed), 1);
    for (int i = 0; i < 4; i++) frame("rev_ramp");
    check("rev_ramp_x", int'(x), 444);
    check("rev_ramp_speed", int'(speed), 2);
    set_btn(1, 1);
    frame("both");
    check("both_speed", int'(speed), 0);
    check("both_x", int'(x), 444);

    // Right wall: one pulse, then pinned.
    hits = 0;
    set_btn(0, 1);
    for (int i = 0; i < 50; i++) frame("rwall");
    check("rwall_x", int'(x), 592);
    check("rwall_pulses", hits, 1);

    // Left wall.
    hits = 0;
    set_btn(1, 0);
    for (int i = 0; i < 110; i++) frame("lwall");
    check("lwall_x", int'(x), 0);
    check("lwall_pulses", hits, 1);
    set_btn(0, 0);
    frame("release");
    check("release_speed", int'(speed), 0);

    // One-cycle glitch between ticks is never seen.
    @(negedge clk) btn_right = 1'b1;
    @(negedge clk) btn_right = 1'b0;
    repeat (3) @(negedge clk);
    frame("glitch");
    check("glitch_x", int'(x), 0);

    // Press one cycle before the tick: synchronizer has not caught up yet.
    @(negedge clk) btn_right = 1'b1;
    frame_ex("late", 1'b0, 1'b0);
    check("late_x", int'(x), 0);
    frame("late_next");
    check("late_next_x", int'(x), 1);

    // Freeze holds the paddle even with right held.
    @(negedge clk) freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame("freeze");
      check("freeze_x", int'(x), 1);
      check("freeze_speed", int'(speed), 0);
    end

    // Back-to-back ticks each count as a full frame.
    @(negedge clk) freeze = 1'b0;
    model_step(1'b0, 1'b1, 1'b0);
    model_step(1'b0, 1'b1, 1'b0);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk) frame_tick = 1'b0;
    check("b2b_x", int'(x), 3);
    check("b2b_speed", int'(speed), 1);
    check("b2b_model_x", int'(x), m_x);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_controller.md
# paddle_controller

Converts the player's raw left/right buttons into the paddle's horizontal position `x`. The paddle painter consumes `x` to draw the paddle. Buttons are synchronized, sampled once per frame on `frame_tick`, and turned into motion with a held-button acceleration ramp. The result is clamped to the playfield, and `x` changes only on a frame tick, so it stays stable across the visible frame.

## Interface

- `SCREEN_WIDTH`, default 640: playfield width in pixels.
- `PADDLE_WIDTH`, default 48: paddle width (8-px segment × 6 segments).
- `X_RESET`, default 296: `x` after reset (paddle centred).
- `MAX_SPEED`, default 8: maximum step in px/frame (≤ 15).
- `ACCEL_FRAMES`, default 4: held frames per +1 speed increment (≥ 1).

- `clk`  in  1  pixel clock.
- `nRst`  in  1  reset, asynchronous, active-low.
- `btn_left`  in  1  raw left button, asynchronous, active-high.
- `btn_right`  in  1  raw right button, asynchronous, active-high.
- `frame_tick`  in  1  single-cycle pulse once per frame, issued in vertical blanking.
- `freeze`  in  1  synchronous; while high, the paddle does not move (serve / pause).
- `x`  out  10  paddle left edge, range [0, SCREEN_WIDTH−PADDLE_WIDTH].
- `speed`  out  4  current step size; 0 when idle.
- `wall_hit`  out  1  one-cycle pulse when a move is clamped at an edge.

## Operation

- **Synchronizer.** Each button passes through a 2-flop synchronizer, reset to 0.
  - Decision uses the synchronized values present at the `frame_tick` edge.
- **Direction decode.**
  - L only → LEFT.
  - R only → RIGHT.
  - Both or neither → NONE.
  - `freeze`=1 forces NONE.
- **State machine.** States are IDLE, LEFT, RIGHT. Updates happen only on an edge where `frame_tick`=1; otherwise all state holds.
  - **dir NONE:** go to IDLE; `speed`←0; `hold_cnt`←0; `x` unchanged.
  - **dir differs from current state** (IDLE→LEFT/RIGHT, or reversal): enter the new state; `speed`←1; `hold_cnt`←0; move `x` by 1.
  - **dir same as current state:** move `x` by the current `speed` (pre-update value).
    - If `hold_cnt`==ACCEL_FRAMES−1: `hold_cnt`←0 and `speed`←min(`speed`+1, MAX_SPEED).
    - Else: `hold_cnt`←`hold_cnt`+1.
- **Arithmetic.** Use 11-bit intermediates; no wrap-around.
  - LEFT: if `x` < step, then `x`←0, else `x`←`x`−step.
  - RIGHT: let XMAX = SCREEN_WIDTH−PADDLE_WIDTH. If `x`+step > XMAX, then `x`←XMAX, else `x`←`x`+step.
- **Wall hit.** `wall_hit`=1 for one cycle when clamping occurred and `x` was not already at the limit.
  - Pushing against a wall while already at the limit: no pulse, `x` unchanged.
  - State and speed continue to evolve as if the move succeeded.
- **Reset values.** `x`=X_RESET, `speed`=0, state IDLE, `hold_cnt`=0, `wall_hit`=0, synchronizer flops 0.
- **Reset mid-operation.** `nRst` low clears everything immediately, independent of `clk`.
  - After release, the first move happens on the first `frame_tick` whose sampled synchronized buttons are non-NONE.

## Timing

- **Button latency.** A button edge reaches the sampling point after 2 `clk` edges.
  - A press must be stable for ≥ 3 cycles before `frame_tick` to be guaranteed seen.
- **Update point.** `x`, `speed` and `wall_hit` update on the same rising edge where `frame_tick`=1; visible on the next cycle.
- **Stability.** `x` is constant for all cycles between frame ticks.
- **`wall_hit` duration.** High for exactly the cycle after the tick edge.
- **Back-to-back ticks.** Ticks on consecutive cycles are legal, and each is processed as a full frame.
- **`freeze` timing.** `freeze` is sampled only on tick edges.

## Test plan

1. **Reset.** Assert `nRst` low mid-frame with the right button held → `x`=296, `speed`=0, `wall_hit`=0 immediately. After release with no buttons and 10 ticks → `x` stays 296.
2. **Acceleration ramp.** Hold right from 296, 6 ticks (ACCEL_FRAMES=4) → `x`=297, 298, 299, 300, 301, 303; `speed` after tick 5 = 2. Keep holding → `speed` saturates at 8 and never exceeds it.
3. **Reversal.** After the ramp in scenario 2, switch to left → first tick `x`−=1, `speed`=1, `hold_cnt` restarts. Both buttons held → IDLE, `speed`=0, `x` frozen.
4. **Right wall.** `x`=590, `speed`=8, right held → next tick `x`=592 with one `wall_hit` pulse. Following ticks: `x`=592, no pulse.
5. **Left wall.** `x`=3, `speed`=5, left held → `x`=0 with a `wall_hit` pulse. Releasing the button → `speed` 0.
6. **Sampling and freeze.**
   - A 1-cycle button glitch between ticks → no movement.
   - Button pressed 1 cycle before a tick → ignored on that tick.
   - `freeze`=1 with right held → `x` unchanged, `speed`=0.
